axis_replay_unpacker: RTL and testbench
=======================================

Name: axis_replay_unpacker

Overview:
Single-clock successor to the replay-path FIFO-to-AXIS converter. It buffers packed replay words (9 bits per byte plus an explicit end-of-packet flag) in an internal synchronous FIFO and emits AXI4-Stream beats through a registered output stage. Per-packet TUSER comes either from an in-band header word or from a configuration port. Adds an explicit EOP flag, a start-of-packet pause gate, and packet/byte counters. Sits between the pcap replay DMA/memory reader and the output port arbiter.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, AXIS data width in bits; must be a multiple of 8.
C_M_AXIS_TUSER_WIDTH, 128, TUSER width; must be <= C_M_AXIS_DATA_WIDTH.
FIFO_DEPTH, 512, FIFO depth in words; power of 2, >= 4.
PROG_FULL_THRESH, 480, occupancy at or above which fifo_prog_full is asserted.
HDR_MODE, 1, 1 = first word of each packet is a TUSER header; 0 = TUSER taken from tuser_cfg.
EOP_MODE, 1, 1 = the explicit EOP bit ends the packet; 0 = legacy: a word whose strobe is not all-ones ends the packet.

Ports:
axi_aclk  in  1  sole clock.
axi_areset  in  1  asynchronous, active-high reset.
sw_rst  in  1  synchronous soft reset; same effect as axi_areset.
fifo_wr_en  in  1  write strobe.
fifo_din  in  PW  PW = 9*C_M_AXIS_DATA_WIDTH/8 + 1. Bit PW-1 = EOP; byte i occupies bits [9i+8:9i] = {strb_i, data_i}.
fifo_full  out  1  FIFO full.
fifo_prog_full  out  1  occupancy >= PROG_FULL_THRESH.
enable  in  1  0 = do not start new packets.
tuser_cfg  in  C_M_AXIS_TUSER_WIDTH  TUSER source when HDR_MODE=0, sampled at start of packet.
m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  output data.
m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  output byte strobes.
m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  output TUSER.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last beat of packet.
pkt_cnt  out  32  count of packets completed (tlast handshakes); wraps.
byte_cnt  out  48  sum of popcount(tstrb) over all handshaken beats; wraps.

Behaviour:
- Reset (async or sw_rst): FIFO emptied; state = SOP; all outputs, counters, and internal registers = 0; fifo_full = fifo_prog_full = 0.
- Writes while fifo_full are ignored; FIFO contents are not corrupted.
- FIFO is first-word-fall-through. Occupancy is counted for reads and writes in the same cycle.
- Output register slot: a word is popped when the FIFO is not empty, the FSM accepts the word, and (!m_axis_tvalid || m_axis_tready). Once tvalid rises, tdata/tstrb/tuser/tlast stay stable until the handshake.
- Latency: a word written to an empty FIFO with the FSM in PKT gives m_axis_tvalid=1 two cycles after fifo_wr_en.
- State SOP:
  - Waits for enable=1 and FIFO not empty.
  - HDR_MODE=1: pops the header word, latches tuser = word data[TUSER-1:0], goes to PKT. No beat is emitted, and the EOP bit of the header is ignored.
  - HDR_MODE=0: latches tuser_cfg and goes to PKT without popping.
- State PKT:
  - Each popped word is loaded into the output register with tdata/tstrb unpacked from fifo_din.
  - tlast = EOP bit (EOP_MODE=1), or tlast = (strb != all-ones) (EOP_MODE=0).
  - When the tlast word is popped, go to SOP.
  - A full-strobe EOP word is a valid last beat in EOP_MODE=1.
- enable=0 mid-packet: the current packet completes; the gate applies only in SOP.
- m_axis_tuser is constant for every beat of a packet.
- The next packet's header may be popped in the same cycle the previous tlast beat handshakes. There are no bubble cycles back-to-back in HDR_MODE=0.
- Counters update on the handshake cycle.
- sw_rst mid-packet: the packet is truncated without tlast; the output is deasserted the next cycle.

Decomposition:
- Package axis_replay_pkg: function for PW; constants for the EOP bit index and the 9-bit byte-lane layout; SOP/PKT state encoding; popcount function.
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH, PROG_FULL_THRESH; ports full/prog_full/empty) holds the storage. The top module holds the FSM, the output register, and the counters.

Test Plan:
- HDR_MODE=1, EOP_MODE=1, tready=1: write header 0xAB, then 3 full words with the last flagged EOP -> 3 beats, tlast on beat 3, tuser=0xAB on all beats, pkt_cnt=1, byte_cnt=96.
- EOP_MODE=0: 2-word packet, second strb=0x0000_00FF -> tlast on beat 2, byte_cnt=40. In EOP_MODE=1 with the same data and no EOP -> no tlast, stays in PKT.
- Backpressure: toggle tready 1/0 every cycle across a 5-beat packet -> tdata/tlast stable while tvalid=1 && tready=0; all 5 beats delivered in order.
- Fill 512 words with the reader stalled (enable=0) -> fifo_prog_full at 480, fifo_full at 512; the 513th write is ignored; drain yields exactly 512 words.
- Drop enable to 0 after beat 1 of a 4-beat packet -> all 4 beats emitted; the next header is not popped until enable=1.
- Assert sw_rst mid-packet, then resume with a fresh packet -> tvalid=0 the next cycle, counters=0, and the new packet's tuser comes from its header.

Source files
------------

// File: rtl/axis_replay_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_replay_pkg
// Brief    : Shared types, packed-word layout and helpers for the replay
//            FIFO-to-AXIS unpacker.
// Revision : 1.0 - initial release
// ============================================================================
package axis_replay_pkg;

  // Each byte lane in a packed replay word is {strb, data[7:0]}.
  localparam int unsigned c_lane_bits      = 9;
  localparam int unsigned c_lane_data_bits = 8;
  localparam int unsigned c_lane_strb_pos  = 8;

  // Widest strobe vector the popcount helper accepts (4096-bit data bus).
  localparam int unsigned c_popcnt_max = 512;

  typedef enum logic [0:0] {
    ST_SOP = 1'b0,
    ST_PKT = 1'b1
  } state_t;

  // Packed word width: 9 bits per byte lane plus the trailing EOP flag.
  function automatic int unsigned packed_width(input int unsigned data_width);
    return c_lane_bits * (data_width / 8) + 1;
  endfunction

  // The EOP flag is the most significant bit of the packed word.
  function automatic int unsigned eop_index(input int unsigned data_width);
    return packed_width(data_width) - 1;
  endfunction

  function automatic logic [15:0] popcount(input logic [c_popcnt_max-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < c_popcnt_max; i++) begin
      n = n + 16'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_replay_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_replay_unpacker_if
// Brief    : AXI4-Stream master bundle (tdata/tstrb/tuser/tvalid/tready/tlast).
// Revision : 1.0 - initial release
// ============================================================================
interface axis_replay_unpacker_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (
    output tdata, tstrb, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tuser, tvalid, tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_replay_unpacker_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : Single-clock first-word-fall-through FIFO with occupancy-based
//            full / programmable-full flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH            = 289,
  parameter int DEPTH            = 512,
  parameter int PROG_FULL_THRESH = 480
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             srst,
  input  wire logic             wr_en,
  input  wire logic [WIDTH-1:0] din,
  output logic                  full,
  output logic                  prog_full,
  input  wire logic             rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth  = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_pf_thr = c_cw'(PROG_FULL_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q;
  logic [c_aw-1:0]  rd_ptr_q;
  logic [c_cw-1:0]  count_q;
  logic             w_wr;
  logic             w_rd;

  // Writes into a full FIFO and reads from an empty one are dropped.
  assign w_wr      = wr_en && !full;
  assign w_rd      = rd_en && !empty;
  assign full      = (count_q == c_depth);
  assign prog_full = (count_q >= c_pf_thr);
  assign empty     = (count_q == '0);
  assign dout      = mem_q[rd_ptr_q];

  // Storage array; left unreset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + c_cw'(w_wr) - c_cw'(w_rd);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_replay_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : axis_replay_unpacker
// Brief    : Buffers packed replay words and emits AXI4-Stream packets through
//            a registered output slot; TUSER from header word or config port.
// Revision : 1.0 - initial release
// ============================================================================
module axis_replay_unpacker
  import axis_replay_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH           = 512,
  parameter int PROG_FULL_THRESH     = 480,
  parameter int HDR_MODE             = 1,
  parameter int EOP_MODE             = 1
) (
  input  wire logic                                         axi_aclk,
  input  wire logic                                         axi_areset,
  input  wire logic                                         sw_rst,
  input  wire logic                                         fifo_wr_en,
  input  wire logic [packed_width(C_M_AXIS_DATA_WIDTH)-1:0] fifo_din,
  output logic                                              fifo_full,
  output logic                                              fifo_prog_full,
  input  wire logic                                         enable,
  input  wire logic [C_M_AXIS_TUSER_WIDTH-1:0]              tuser_cfg,
  axis_replay_unpacker_if.master                            m_axis,
  output logic [31:0]                                       pkt_cnt,
  output logic [47:0]                                       byte_cnt
);

  localparam int c_pw    = packed_width(C_M_AXIS_DATA_WIDTH);
  localparam int c_lanes = C_M_AXIS_DATA_WIDTH / 8;
  localparam int c_eop   = eop_index(C_M_AXIS_DATA_WIDTH);
  localparam int c_dw    = C_M_AXIS_DATA_WIDTH;
  localparam int c_tw    = C_M_AXIS_TUSER_WIDTH;

  state_t                  state_q, state_d;
  logic [c_tw-1:0]         tuser_q, tuser_d;
  logic [c_dw-1:0]         tdata_q;
  logic [c_lanes-1:0]      tstrb_q;
  logic [c_tw-1:0]         tuser_out_q;
  logic                    tlast_q;
  logic                    tvalid_q;
  logic [31:0]             pkt_cnt_q;
  logic [47:0]             byte_cnt_q;

  logic [c_pw-1:0]         w_dout;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_load;
  logic [c_tw-1:0]         w_load_user;
  logic [c_dw-1:0]         w_data;
  logic [c_lanes-1:0]      w_strb;
  logic                    w_last;
  logic                    w_out_free;
  logic                    w_handshake;
  logic [c_popcnt_max-1:0] w_strb_ext;

  sync_fifo_fwft #(
    .WIDTH            (c_pw),
    .DEPTH            (FIFO_DEPTH),
    .PROG_FULL_THRESH (PROG_FULL_THRESH)
  ) u_fifo (
    .clk       (axi_aclk),
    .rst       (axi_areset),
    .srst      (sw_rst),
    .wr_en     (fifo_wr_en),
    .din       (fifo_din),
    .full      (fifo_full),
    .prog_full (fifo_prog_full),
    .rd_en     (w_pop),
    .dout      (w_dout),
    .empty     (w_empty)
  );

  for (genvar i = 0; i < c_lanes; i++) begin : g_lane
    assign w_data[8*i +: 8] = w_dout[c_lane_bits*i +: c_lane_data_bits];
    assign w_strb[i]        = w_dout[c_lane_bits*i + c_lane_strb_pos];
  end

  // Legacy mode ends a packet on the first partially-strobed word.
  assign w_last      = (EOP_MODE != 0) ? w_dout[c_eop] : (w_strb != '1);
  assign w_out_free  = !tvalid_q || m_axis.tready;
  assign w_handshake = tvalid_q && m_axis.tready;
  assign w_strb_ext  = c_popcnt_max'(tstrb_q);

  // Packet framing: decide when to pop and whether the word becomes a beat.
  always_comb begin
    state_d     = state_q;
    tuser_d     = tuser_q;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_user = tuser_q;
    unique case (state_q)
      ST_SOP: begin
        if (enable && !w_empty) begin
          if (HDR_MODE != 0) begin
            // Header is consumed without a beat, so the output slot is irrelevant.
            w_pop   = 1'b1;
            tuser_d = w_data[c_tw-1:0];
            state_d = ST_PKT;
          end else if (w_out_free) begin
            // First beat leaves together with the config sample: no SOP bubble.
            w_pop       = 1'b1;
            w_load      = 1'b1;
            tuser_d     = tuser_cfg;
            w_load_user = tuser_cfg;
            state_d     = w_last ? ST_SOP : ST_PKT;
          end
        end
      end
      ST_PKT: begin
        if (!w_empty && w_out_free) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
          if (w_last) state_d = ST_SOP;
        end
      end
      default: state_d = ST_SOP;
    endcase
  end

  // Framing state and the per-packet TUSER latch.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q <= ST_SOP;
      tuser_q <= '0;
    end else if (sw_rst) begin
      state_q <= ST_SOP;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      tuser_q <= tuser_d;
    end
  end

  // Output slot: load on pop, hold until handshake, drop on soft reset.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tuser_out_q <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
    end else if (sw_rst) begin
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tuser_out_q <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
    end else if (w_load) begin
      tdata_q     <= w_data;
      tstrb_q     <= w_strb;
      tuser_out_q <= w_load_user;
      tlast_q     <= w_last;
      tvalid_q    <= 1'b1;
    end else if (w_handshake) begin
      tvalid_q    <= 1'b0;
    end
  end

  // Packet and byte statistics, advanced on each accepted beat.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (sw_rst) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (w_handshake) begin
      pkt_cnt_q  <= pkt_cnt_q + 32'(tlast_q);
      byte_cnt_q <= byte_cnt_q + 48'(popcount(w_strb_ext));
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tstrb  = tstrb_q;
  assign m_axis.tuser  = tuser_out_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tvalid = tvalid_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign byte_cnt      = byte_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_replay_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_replay_unpacker
// Brief    : Scoreboard bench for axis_replay_unpacker; instance A runs header
//            + explicit EOP mode, instance B runs config-TUSER + legacy EOP.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_replay_unpacker;

  localparam int DW = 256;
  localparam int TW = 128;
  localparam int NL = DW / 8;
  localparam int PW = 9 * NL + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [NL-1:0] strb;
    logic [TW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;

  // instance A signals
  logic          sw_rst_a = 1'b0, wr_en_a = 1'b0, enable_a = 1'b1;
  logic [PW-1:0] din_a = '0;
  logic [TW-1:0] tcfg_a = '0;
  logic          full_a, pfull_a;
  logic [31:0]   pkt_a;
  logic [47:0]   bytes_a;
  // instance B signals
  logic          sw_rst_b = 1'b0, wr_en_b = 1'b0, enable_b = 1'b1;
  logic [PW-1:0] din_b = '0;
  logic [TW-1:0] tcfg_b = '0;
  logic          full_b, pfull_b;
  logic [31:0]   pkt_b;
  logic [47:0]   bytes_b;

  axis_replay_unpacker_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) ax_a ();
  axis_replay_unpacker_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) ax_b ();

  beat_t q_a[$];
  beat_t q_b[$];
  int    exp_pkt_a = 0;
  longint exp_bytes_a = 0;

  logic          stab_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [TW-1:0] prev_user;
  logic          prev_last;
  int            hs_prev = 0, hs_last = 0;

  axis_replay_unpacker #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(TW), .FIFO_DEPTH(512),
    .PROG_FULL_THRESH(480), .HDR_MODE(1), .EOP_MODE(1)
  ) u_a (
    .axi_aclk(clk), .axi_areset(rst), .sw_rst(sw_rst_a), .fifo_wr_en(wr_en_a),
    .fifo_din(din_a), .fifo_full(full_a), .fifo_prog_full(pfull_a),
    .enable(enable_a), .tuser_cfg(tcfg_a), .m_axis(ax_a), .pkt_cnt(pkt_a),
    .byte_cnt(bytes_a)
  );

  axis_replay_unpacker #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(TW), .FIFO_DEPTH(16),
    .PROG_FULL_THRESH(12), .HDR_MODE(0), .EOP_MODE(0)
  ) u_b (
    .axi_aclk(clk), .axi_areset(rst), .sw_rst(sw_rst_b), .fifo_wr_en(wr_en_b),
    .fifo_din(din_b), .fifo_full(full_b), .fifo_prog_full(pfull_b),
    .enable(enable_b), .tuser_cfg(tcfg_b), .m_axis(ax_b), .pkt_cnt(pkt_b),
    .byte_cnt(bytes_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int pc(input logic [NL-1:0] s);
    int n = 0;
    for (int i = 0; i < NL; i++) n += int'(s[i]);
    return n;
  endfunction

  function automatic logic [PW-1:0] mk_word(input logic [DW-1:0] d, input logic [NL-1:0] s, input logic eop);
    logic [PW-1:0] w;
    w = '0;
    for (int i = 0; i < NL; i++) begin
      w[9*i +: 8] = d[8*i +: 8];
      w[9*i+8]    = s[i];
    end
    w[PW-1] = eop;
    return w;
  endfunction

  function automatic logic [DW-1:0] dat(input int k);
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'(k * 8 + i) ^ 32'hC0DE_0000;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [PW-1:0] w);
    din_a = w; wr_en_a = 1'b1; tick(); wr_en_a = 1'b0;
  endtask

  task automatic wr_b(input logic [PW-1:0] w);
    din_b = w; wr_en_b = 1'b1; tick(); wr_en_b = 1'b0;
  endtask

  task automatic hdr_a(input logic [TW-1:0] u, input logic eop);
    wr_a(mk_word(DW'(u), '1, eop));
  endtask

  // EOP_MODE=1: the explicit flag marks the last beat.
  task automatic beat_a(input logic [DW-1:0] d, input logic [NL-1:0] s, input logic eop, input logic [TW-1:0] u);
    q_a.push_back('{data: d, strb: s, user: u, last: eop});
    exp_pkt_a += int'(eop);
    exp_bytes_a += longint'(pc(s));
    wr_a(mk_word(d, s, eop));
  endtask

  // EOP_MODE=0: a partial strobe marks the last beat; the EOP flag is ignored.
  task automatic beat_b(input logic [DW-1:0] d, input logic [NL-1:0] s, input logic eop, input logic [TW-1:0] u);
    q_b.push_back('{data: d, strb: s, user: u, last: (s != '1)});
    wr_b(mk_word(d, s, eop));
  endtask

  task automatic wait_idle_a(input string nm, input int budget);
    int n = 0;
    while (q_a.size() != 0 && n < budget) begin tick(); n++; end
    tick();
    chk(nm, 64'(q_a.size()), 64'd0);
  endtask

  task automatic wait_idle_b(input string nm, input int budget);
    int n = 0;
    while (q_b.size() != 0 && n < budget) begin tick(); n++; end
    tick();
    chk(nm, 64'(q_b.size()), 64'd0);
  endtask

  // Monitor A: scoreboard pop on handshake plus hold-stability during stalls.
  always @(negedge clk) begin
    if (stab_en && prev_stall) begin
      nvec++;
      if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== prev_data || ax_a.tlast !== prev_last || ax_a.tuser !== prev_user) begin
        nfail++;
        $display("FAIL a_stall_hold got v=%b last=%b data=%h want v=1 last=%b data=%h",
                 ax_a.tvalid, ax_a.tlast, ax_a.tdata, prev_last, prev_data);
      end
    end
    prev_stall = ax_a.tvalid && !ax_a.tready;
    prev_data  = ax_a.tdata;
    prev_user  = ax_a.tuser;
    prev_last  = ax_a.tlast;
    if (ax_a.tvalid === 1'b1 && ax_a.tready === 1'b1) begin
      nvec++;
      if (q_a.size() == 0) begin
        nfail++;
        $display("FAIL a_unexpected_beat got data=%h want no beat", ax_a.tdata);
      end else begin
        beat_t e;
        e = q_a.pop_front();
        if (ax_a.tdata !== e.data || ax_a.tstrb !== e.strb || ax_a.tuser !== e.user || ax_a.tlast !== e.last) begin
          nfail++;
          $display("FAIL a_beat got data=%h strb=%h user=%h last=%b want data=%h strb=%h user=%h last=%b",
                   ax_a.tdata, ax_a.tstrb, ax_a.tuser, ax_a.tlast, e.data, e.strb, e.user, e.last);
        end
      end
    end
  end

  // Monitor B: scoreboard pop on handshake, records handshake cycles.
  always @(negedge clk) begin
    if (ax_b.tvalid === 1'b1 && ax_b.tready === 1'b1) begin
      hs_prev = hs_last;
      hs_last = cyc;
      nvec++;
      if (q_b.size() == 0) begin
        nfail++;
        $display("FAIL b_unexpected_beat got data=%h want no beat", ax_b.tdata);
      end else begin
        beat_t e;
        e = q_b.pop_front();
        if (ax_b.tdata !== e.data || ax_b.tstrb !== e.strb || ax_b.tuser !== e.user || ax_b.tlast !== e.last) begin
          nfail++;
          $display("FAIL b_beat got data=%h strb=%h user=%h last=%b want data=%h strb=%h user=%h last=%b",
                   ax_b.tdata, ax_b.tstrb, ax_b.tuser, ax_b.tlast, e.data, e.strb, e.user, e.last);
        end
      end
    end
  end

  initial begin
    ax_a.tready = 1'b1;
    ax_b.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // reset state
    chk("rst_tvalid_a", 64'(ax_a.tvalid), 64'd0);
    chk("rst_tlast_a", 64'(ax_a.tlast), 64'd0);
    chk("rst_tdata_a", 64'(|ax_a.tdata), 64'd0);
    chk("rst_pkt_a", 64'(pkt_a), 64'd0);
    chk("rst_bytes_a", 64'(bytes_a), 64'd0);
    chk("rst_full_a", 64'({full_a, pfull_a}), 64'd0);
    chk("rst_tvalid_b", 64'(ax_b.tvalid), 64'd0);

    // T1: header 0xAB + 3 full beats, EOP on the third; check 2-cycle latency
    hdr_a(128'hAB, 1'b0);
    repeat (2) tick();
    beat_a(dat(1), '1, 1'b0, 128'hAB);
    chk("t1_lat_c1", 64'(ax_a.tvalid), 64'd0);
    tick();
    chk("t1_lat_c2", 64'(ax_a.tvalid), 64'd1);
    beat_a(dat(2), '1, 1'b0, 128'hAB);
    beat_a(dat(3), '1, 1'b1, 128'hAB);
    wait_idle_a("t1_drain", 50);
    chk("t1_pkt", 64'(pkt_a), 64'd1);
    chk("t1_bytes", 64'(bytes_a), 64'd96);

    // T2: legacy EOP on instance B; full word with EOP flag is not last
    tcfg_b = 128'h55;
    beat_b(dat(70), '1, 1'b1, 128'h55);
    beat_b(dat(71), 32'h0000_00FF, 1'b0, 128'h55);
    wait_idle_b("t2_drain", 50);
    chk("t2_pkt", 64'(pkt_b), 64'd1);
    chk("t2_bytes", 64'(bytes_b), 64'd40);
    tcfg_b = 128'h99;
    beat_b(dat(72), 32'h0000_000F, 1'b0, 128'h99);
    beat_b(dat(73), 32'h0000_0001, 1'b0, 128'h99);
    wait_idle_b("t2_b2b_drain", 50);
    chk("t2_no_bubble", 64'(hs_last - hs_prev), 64'd1);
    chk("t2_pkt2", 64'(pkt_b), 64'd3);
    chk("t2_bytes2", 64'(bytes_b), 64'd45);

    // T3: partial strobe without EOP stays in packet; next word closes it
    hdr_a(128'h11, 1'b0);
    beat_a(dat(20), '1, 1'b0, 128'h11);
    beat_a(dat(21), 32'h0000_00FF, 1'b0, 128'h11);
    wait_idle_a("t3_drain", 50);
    repeat (5) tick();
    chk("t3_idle_tvalid", 64'(ax_a.tvalid), 64'd0);
    beat_a(dat(22), '1, 1'b1, 128'h11);
    wait_idle_a("t3_close", 50);
    chk("t3_pkt", 64'(pkt_a), 64'(exp_pkt_a));
    chk("t3_bytes", 64'(bytes_a), 64'(exp_bytes_a));

    // T4: backpressure toggling across a 5-beat packet
    ax_a.tready = 1'b0;
    hdr_a(128'h44, 1'b0);
    for (int k = 0; k < 5; k++) beat_a(dat(30 + k), (k == 2) ? 32'h0F0F_0F0F : '1, k == 4, 128'h44);
    stab_en = 1'b1;
    repeat (24) begin ax_a.tready = ~ax_a.tready; tick(); end
    ax_a.tready = 1'b1;
    stab_en = 1'b0;
    wait_idle_a("t4_drain", 50);
    chk("t4_pkt", 64'(pkt_a), 64'(exp_pkt_a));
    chk("t4_bytes", 64'(bytes_a), 64'(exp_bytes_a));

    // T5: enable dropped after beat 1; packet completes, next header held
    hdr_a(128'h21, 1'b0);
    beat_a(dat(40), '1, 1'b0, 128'h21);
    repeat (3) tick();
    enable_a = 1'b0;
    beat_a(dat(41), '1, 1'b0, 128'h21);
    beat_a(dat(42), '1, 1'b0, 128'h21);
    beat_a(dat(43), '1, 1'b1, 128'h21);
    hdr_a(128'h22, 1'b0);
    beat_a(dat(44), '1, 1'b1, 128'h22);
    repeat (10) tick();
    chk("t5_held_q", 64'(q_a.size()), 64'd1);
    chk("t5_held_tvalid", 64'(ax_a.tvalid), 64'd0);
    enable_a = 1'b1;
    wait_idle_a("t5_drain", 50);
    chk("t5_pkt", 64'(pkt_a), 64'(exp_pkt_a));

    // T6: fill 512 with reader gated, check flags, 513th write ignored
    enable_a = 1'b0;
    for (int k = 0; k < 512; k++) begin
      if (k == 0) hdr_a(128'h5A, 1'b0);
      else beat_a(dat(100 + k), '1, k == 511, 128'h5A);
      if (k == 478) chk("t6_pf_479", 64'(pfull_a), 64'd0);
      if (k == 479) chk("t6_pf_480", 64'(pfull_a), 64'd1);
      if (k == 510) chk("t6_full_511", 64'(full_a), 64'd0);
      if (k == 511) chk("t6_full_512", 64'(full_a), 64'd1);
    end
    wr_a(mk_word(dat(999), '1, 1'b1));
    chk("t6_full_513", 64'(full_a), 64'd1);
    enable_a = 1'b1;
    wait_idle_a("t6_drain", 1200);
    repeat (5) tick();
    chk("t6_empty_flags", 64'({full_a, pfull_a, ax_a.tvalid}), 64'd0);
    chk("t6_pkt", 64'(pkt_a), 64'(exp_pkt_a));
    chk("t6_bytes", 64'(bytes_a), 64'(exp_bytes_a));

    // T7: soft reset mid-packet, then a fresh packet (header EOP bit ignored)
    ax_a.tready = 1'b0;
    hdr_a(128'h77, 1'b1);
    wr_a(mk_word(dat(60), '1, 1'b0));
    wr_a(mk_word(dat(61), '1, 1'b0));
    repeat (3) tick();
    chk("t7_pre_tvalid", 64'(ax_a.tvalid), 64'd1);
    sw_rst_a = 1'b1;
    tick();
    sw_rst_a = 1'b0;
    chk("t7_tvalid", 64'(ax_a.tvalid), 64'd0);
    chk("t7_pkt", 64'(pkt_a), 64'd0);
    chk("t7_bytes", 64'(bytes_a), 64'd0);
    exp_pkt_a = 0;
    exp_bytes_a = 0;
    ax_a.tready = 1'b1;
    hdr_a(128'hC3, 1'b1);
    beat_a(dat(62), '1, 1'b0, 128'hC3);
    beat_a(dat(63), '1, 1'b1, 128'hC3);
    wait_idle_a("t7_drain", 50);
    repeat (5) tick();
    chk("t7_pkt_after", 64'(pkt_a), 64'd1);
    chk("t7_bytes_after", 64'(bytes_a), 64'd64);
    chk("end_q_b", 64'(q_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
